// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive oversampler.
package uart_rx_pkg;

    localparam int unsigned MAX_SAMPLES = 32'd7;

    // Smallest bit period that leaves room for the sample window plus a strobe edge.
    function automatic int unsigned min_prescale(input int unsigned n);
        return n + 32'd3;
    endfunction

    function automatic int unsigned window_first(input int unsigned p, input int unsigned n);
        return (p >> 1) - (n >> 1);
    endfunction

endpackage

// File: rtl/uart_rx_oversampler_if.sv
// Bundle between the receiver FSM (master) and the oversampler (slave).
interface uart_rx_oversampler_if #(
    parameter int unsigned PRESCALE_WIDTH = 6
);
    logic                      serial_data_in;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      enable;
    logic                      bit_restart;
    logic [PRESCALE_WIDTH-1:0] edge_count;
    logic                      sampled_bit;
    logic                      sample_valid;
    logic                      bit_end;
    logic                      noise_error;

    modport master (
        output serial_data_in, prescale, enable, bit_restart,
        input  edge_count, sampled_bit, sample_valid, bit_end, noise_error
    );

    modport slave (
        input  serial_data_in, prescale, enable, bit_restart,
        output edge_count, sampled_bit, sample_valid, bit_end, noise_error
    );
endinterface

// File: rtl/majority_voter.sv
// Combinational majority vote and agreement flag over N samples.
module majority_voter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] samples,
    output logic         vote,
    output logic         unanimous
);
    logic [3:0] ones_s;

    // Population count, majority decision and all-equal detection.
    always_comb begin
        ones_s = 4'd0;
        for (int i = 0; i < int'(N); i++) begin
            ones_s = ones_s + 4'(samples[i]);
        end
        vote      = (ones_s > 4'(N >> 1));
        unanimous = (samples == {N{1'b0}}) || (samples == {N{1'b1}});
    end
endmodule

// File: rtl/uart_rx_oversampler.sv
// Oversampling bit sampler: edge counter, mid-bit window and majority vote.
// Optional disagreement flag enabled by defining UART_RX_NOISE_DETECT_EN.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned NUM_SAMPLES    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_rx_oversampler_if.slave  bus
);
    localparam int unsigned PW = PRESCALE_WIDTH;
    localparam int unsigned N  = NUM_SAMPLES;
    localparam logic [PW-1:0] MIN_P  = PW'(min_prescale(N));
    localparam logic [PW-1:0] ONE_C  = PW'(1'b1);
    localparam logic [PW-1:0] SPAN_C = PW'(N - 32'd1);
    localparam logic [PW-1:0] ZERO_C = {PW{1'b0}};

    if (((N % 32'd2) != 32'd1) || (N > MAX_SAMPLES)) begin : g_bad_num_samples
        $error("NUM_SAMPLES must be odd and at most %0d", MAX_SAMPLES);
    end
    if (((32'd1 << PW) - 32'd1) < min_prescale(N)) begin : g_bad_prescale_width
        $error("PRESCALE_WIDTH too narrow for NUM_SAMPLES");
    end

    logic [PW-1:0] p_eff_s;
    logic [PW-1:0] p_last_s;
    logic [PW-1:0] first_s;
    logic [PW-1:0] last_s;
    logic [PW-1:0] count_next_s;
    logic          in_window_s;
    logic [N:0]    shift_s;
    logic [N-1:0]  samples_next_s;
    logic          vote_s;
    logic          unanimous_s;
    logic          noise_next_s;

    logic [PW-1:0] count_r;
    logic [N-1:0]  samples_r;
    logic          sampled_bit_r;
    logic          sample_valid_r;
    logic          bit_end_r;
    logic          noise_r;

    // Effective period, window bounds and next counter value.
    always_comb begin
        p_eff_s        = (bus.prescale < MIN_P) ? MIN_P : bus.prescale;
        p_last_s       = p_eff_s - ONE_C;
        first_s        = PW'(window_first(32'(p_eff_s), N));
        last_s         = first_s + SPAN_C;
        in_window_s    = (count_r >= first_s) && (count_r <= last_s);
        shift_s        = {samples_r, bus.serial_data_in};
        samples_next_s = shift_s[N-1:0];
        if (!bus.enable) begin
            count_next_s = ZERO_C;
        end else if (bus.bit_restart) begin
            count_next_s = ZERO_C;
        end else if (count_r >= p_last_s) begin
            count_next_s = ZERO_C;
        end else begin
            count_next_s = count_r + ONE_C;
        end
    end

    // The vote includes the sample being captured on the LAST edge.
    majority_voter #(.N(N)) u_voter (
        .samples   (samples_next_s),
        .vote      (vote_s),
        .unanimous (unanimous_s)
    );

`ifdef UART_RX_NOISE_DETECT_EN
    assign noise_next_s = ~unanimous_s;
`else
    logic unused_unanimous_s;
    assign unused_unanimous_s = unanimous_s;
    assign noise_next_s       = 1'b0;
`endif

    // Counter, sample shift register and registered vote outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r        <= ZERO_C;
            samples_r      <= {N{1'b0}};
            sampled_bit_r  <= 1'b0;
            sample_valid_r <= 1'b0;
            bit_end_r      <= 1'b0;
            noise_r        <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            bit_end_r <= (count_next_s == p_last_s);
            if (!bus.enable || bus.bit_restart) begin
                samples_r      <= {N{1'b0}};
                sample_valid_r <= 1'b0;
                noise_r        <= 1'b0;
            end else begin
                if (in_window_s) begin
                    samples_r <= samples_next_s;
                end else begin
                    samples_r <= samples_r;
                end
                if (count_r == last_s) begin
                    sampled_bit_r  <= vote_s;
                    sample_valid_r <= 1'b1;
                    noise_r        <= noise_next_s;
                end else begin
                    sample_valid_r <= 1'b0;
                    noise_r        <= 1'b0;
                end
            end
        end
    end

    assign bus.edge_count   = count_r;
    assign bus.sampled_bit  = sampled_bit_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.bit_end      = bit_end_r;
    assign bus.noise_error  = noise_r;
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboarded bench: N=3 instance for timing scenarios, N=5 instance for voting/noise.
module tb_uart_rx_oversampler;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        logic        b;
        int unsigned edge_idx;
        logic        noise;
    } exp_t;

    exp_t q3[$];
    exp_t q5[$];

`ifdef UART_RX_NOISE_DETECT_EN
    localparam logic NOISE_ON = 1'b1;
`else
    localparam logic NOISE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_oversampler_if #(.PRESCALE_WIDTH(6)) bus3 ();
    uart_rx_oversampler_if #(.PRESCALE_WIDTH(6)) bus5 ();

    uart_rx_oversampler #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );
    uart_rx_oversampler #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(5)) dut5 (
        .clk(clk), .reset(reset), .bus(bus5)
    );

    // Scoreboard pop for the N=3 instance on every strobe.
    always @(negedge clk) begin : mon3
        exp_t e;
        if (!reset && bus3.sample_valid) begin
            n_checks++;
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL dut3_unexpected_strobe: strobe at edge_count=%0d, none expected", bus3.edge_count);
            end else begin
                e = q3.pop_front();
                if (bus3.sampled_bit !== e.b) begin
                    n_fail++;
                    $display("FAIL dut3_bit: got %b expected %b", bus3.sampled_bit, e.b);
                end
                n_checks++;
                if (int'(bus3.edge_count) != int'(e.edge_idx)) begin
                    n_fail++;
                    $display("FAIL dut3_strobe_edge: got %0d expected %0d", bus3.edge_count, e.edge_idx);
                end
                n_checks++;
                if (bus3.noise_error !== e.noise) begin
                    n_fail++;
                    $display("FAIL dut3_noise: got %b expected %b", bus3.noise_error, e.noise);
                end
            end
        end
    end

    // Scoreboard pop for the N=5 instance on every strobe.
    always @(negedge clk) begin : mon5
        exp_t e;
        if (!reset && bus5.sample_valid) begin
            n_checks++;
            if (q5.size() == 0) begin
                n_fail++;
                $display("FAIL dut5_unexpected_strobe: strobe at edge_count=%0d, none expected", bus5.edge_count);
            end else begin
                e = q5.pop_front();
                if (bus5.sampled_bit !== e.b) begin
                    n_fail++;
                    $display("FAIL dut5_bit: got %b expected %b", bus5.sampled_bit, e.b);
                end
                n_checks++;
                if (int'(bus5.edge_count) != int'(e.edge_idx)) begin
                    n_fail++;
                    $display("FAIL dut5_strobe_edge: got %0d expected %0d", bus5.edge_count, e.edge_idx);
                end
                n_checks++;
                if (bus5.noise_error !== e.noise) begin
                    n_fail++;
                    $display("FAIL dut5_noise: got %b expected %b", bus5.noise_error, e.noise);
                end
            end
        end
    end

    // One bit period on dut3 with a constant line; the counter is checked every cycle.
    task automatic run_bit3(input logic b, input int p, input int unsigned vedge, input int first_i);
        exp_t e;
        e.b = b; e.edge_idx = vedge; e.noise = 1'b0;
        q3.push_back(e);
        for (int i = first_i; i < p; i++) begin
            @(negedge clk);
            n_checks++;
            if (int'(bus3.edge_count) != i) begin
                n_fail++;
                $display("FAIL dut3_count: got %0d expected %0d", bus3.edge_count, i);
            end
            n_checks++;
            if (bus3.bit_end !== (i == p - 1)) begin
                n_fail++;
                $display("FAIL dut3_bit_end: got %b expected %b at count %0d", bus3.bit_end, (i == p - 1), i);
            end
            bus3.serial_data_in = b;
            bus3.enable         = 1'b1;
            bus3.bit_restart    = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus3.serial_data_in = 1'b0; bus3.prescale = 6'd8;  bus3.enable = 1'b0; bus3.bit_restart = 1'b0;
        bus5.serial_data_in = 1'b1; bus5.prescale = 6'd16; bus5.enable = 1'b0; bus5.bit_restart = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus3.edge_count, bus3.sampled_bit, bus3.sample_valid, bus3.bit_end, bus3.noise_error} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_dut3: got %b expected all zero",
                     {bus3.edge_count, bus3.sampled_bit, bus3.sample_valid, bus3.bit_end, bus3.noise_error});
        end
        n_checks++;
        if ({bus5.edge_count, bus5.sampled_bit, bus5.sample_valid, bus5.bit_end, bus5.noise_error} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_dut5: got %b expected all zero",
                     {bus5.edge_count, bus5.sampled_bit, bus5.sample_valid, bus5.bit_end, bus5.noise_error});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus3.edge_count !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_count: got %0d expected 0 while disabled", bus3.edge_count);
        end
    endtask

    task automatic check_drained(input string name);
        @(posedge clk);
        n_checks++;
        if (q3.size() != 0 || q5.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_strobe: %0d/%0d strobes outstanding, expected 0", name, q3.size(), q5.size());
        end
    endtask

    task automatic test_basic();
        run_bit3(1'b0, 8, 6, 0);
        run_bit3(1'b1, 8, 6, 0);
        run_bit3(1'b0, 8, 6, 0);
        run_bit3(1'b1, 8, 6, 0);
        check_drained("basic");
    endtask

    task automatic test_restart();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (int'(bus3.edge_count) != i) begin
                n_fail++;
                $display("FAIL restart_pre_count: got %0d expected %0d", bus3.edge_count, i);
            end
            bus3.serial_data_in = 1'b1;
            bus3.bit_restart    = (i == 4);
        end
        @(negedge clk);
        n_checks++;
        if (bus3.edge_count !== 6'd0) begin
            n_fail++;
            $display("FAIL restart_count: got %0d expected 0", bus3.edge_count);
        end
        bus3.bit_restart    = 1'b0;
        bus3.serial_data_in = 1'b0;
        run_bit3(1'b0, 8, 6, 1);
        check_drained("restart");
    endtask

    task automatic test_clamp();
        @(negedge clk);
        bus3.enable   = 1'b0;
        bus3.prescale = 6'd3;
        run_bit3(1'b1, 6, 5, 0);
        run_bit3(1'b0, 6, 5, 0);
        run_bit3(1'b1, 6, 5, 0);
        check_drained("clamp");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus3.enable   = 1'b0;
        bus3.prescale = 6'd8;
        run_bit3(1'b1, 8, 6, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus3.serial_data_in = 1'b1;
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus3.edge_count, bus3.sampled_bit, bus3.sample_valid, bus3.bit_end, bus3.noise_error} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b expected all zero",
                     {bus3.edge_count, bus3.sampled_bit, bus3.sample_valid, bus3.bit_end, bus3.noise_error});
        end
        @(negedge clk);
        reset = 1'b0;
        run_bit3(1'b1, 8, 6, 1);
        check_drained("reset_mid");
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus3.serial_data_in = 1'b0;
            bus3.enable         = (i != 4);
        end
        @(negedge clk);
        n_checks++;
        if (bus3.edge_count !== 6'd0) begin
            n_fail++;
            $display("FAIL enable_drop_count: got %0d expected 0", bus3.edge_count);
        end
        n_checks++;
        if (bus3.sampled_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_drop_hold: got %b expected 1", bus3.sampled_bit);
        end
        run_bit3(1'b0, 8, 6, 0);
        check_drained("enable_drop");
    endtask

    task automatic test_noise5();
        exp_t e;
        @(negedge clk);
        bus3.enable = 1'b0;
        for (int b = 0; b < 2; b++) begin
            e.b = 1'b1; e.edge_idx = 11; e.noise = (b == 0) ? NOISE_ON : 1'b0;
            q5.push_back(e);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                n_checks++;
                if (int'(bus5.edge_count) != i) begin
                    n_fail++;
                    $display("FAIL dut5_count: got %0d expected %0d", bus5.edge_count, i);
                end
                n_checks++;
                if (bus5.bit_end !== (i == 15)) begin
                    n_fail++;
                    $display("FAIL dut5_bit_end: got %b expected %b at count %0d", bus5.bit_end, (i == 15), i);
                end
                bus5.serial_data_in = !((b == 0) && (i == 7));
                bus5.enable         = 1'b1;
            end
        end
        check_drained("noise5");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_clamp();
        test_reset_mid();
        test_enable_drop();
        test_noise5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
